// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM state encodings
// used by the fetch controller and decoded by the debug display.
package fetch_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Command, hazard, branch and breakpoint inputs plus the fetch controls
// driven into the IF stage and pipeline registers.
interface fetch_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);

  logic                                run_req;
  logic                                halt_req;
  logic                                step_req;
  logic                                load_use_hazard;
  logic                                ctrl_branch;
  logic [PC_W-1:0]                     branch_target;
  logic                                bp_en;
  logic [PC_W-1:0]                     bp_addr;
  logic [PC_W-1:0]                     npc;
  logic                                if_id_write;
  logic                                if_id_flush;
  logic                                id_ex_bubble;
  logic [fetch_ctrl_pkg::STATE_W-1:0]  state;
  logic [CNT_W-1:0]                    fetch_cnt;

  modport master (
    input  run_req, halt_req, step_req, load_use_hazard,
    input  ctrl_branch, branch_target, bp_en, bp_addr,
    output npc, if_id_write, if_id_flush, id_ex_bubble, state, fetch_cnt
  );

  modport slave (
    output run_req, halt_req, step_req, load_use_hazard,
    output ctrl_branch, branch_target, bp_en, bp_addr,
    input  npc, if_id_write, if_id_flush, id_ex_bubble, state, fetch_cnt
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: owns the fetch PC and chooses hold, sequential
// fetch or branch redirect under run/halt/step, load-use stalls and a breakpoint.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  fetch_ctrl_if.master bus
);

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     state_r;
  logic [PC_W-1:0]  pc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             bp_hit_s;
  logic             accept_s;
  logic [PC_W-1:0]  npc_s;

  function automatic logic [PC_W-1:0] sel_npc(
    input logic            acc,
    input logic            br,
    input logic [PC_W-1:0] tgt,
    input logic [PC_W-1:0] pc
  );
    logic [PC_W-1:0] r;
    if (!acc) begin
      r = pc;
    end else if (br) begin
      r = tgt;
    end else begin
      r = pc + PC_ONE;
    end
    return r;
  endfunction

  // Accept decision and next-PC selection; a pending halt cancels a step fetch
  always_comb begin
    bp_hit_s = bus.bp_en && (state_r == ST_RUN) && (pc_r == bus.bp_addr);
    accept_s = 1'b0;
    case (state_r)
      ST_RUN:  accept_s = !bus.load_use_hazard && !bp_hit_s;
      ST_STEP: accept_s = !bus.load_use_hazard && !bus.halt_req;
      default: accept_s = 1'b0;
    endcase
    npc_s = sel_npc(accept_s, bus.ctrl_branch, bus.branch_target, pc_r);
  end

  assign bus.npc          = npc_s;
  assign bus.if_id_write  = accept_s;
  assign bus.if_id_flush  = accept_s && bus.ctrl_branch;
  assign bus.id_ex_bubble = !accept_s;
  assign bus.state        = state_r;
  assign bus.fetch_cnt    = cnt_r;

  // PC, fetch counter and run/halt/step FSM; the unused encoding recovers to HALT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r    <= RESET_PC;
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= ST_HALT;
    end else begin
      pc_r  <= npc_s;
      cnt_r <= accept_s ? (cnt_r + CNT_ONE) : cnt_r;
      case (state_r)
        ST_HALT: begin
          if (bus.halt_req) begin
            state_r <= ST_HALT;
          end else if (bus.run_req) begin
            state_r <= ST_RUN;
          end else if (bus.step_req) begin
            state_r <= ST_STEP;
          end else begin
            state_r <= ST_HALT;
          end
        end
        ST_RUN: begin
          if (bus.halt_req || bp_hit_s) begin
            state_r <= ST_HALT;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: begin
          if (bus.halt_req || accept_s) begin
            state_r <= ST_HALT;
          end else begin
            state_r <= ST_STEP;
          end
        end
        default: state_r <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_ctrl;

  logic clk;
  logic rst;

  fetch_ctrl_if #(.PC_W(32), .CNT_W(16)) bus ();

  fetch_ctrl #(.PC_W(32), .RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        wr;
    logic        fl;
    logic        bub;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, "npc",    bus.npc,                   e.npc);
      chk(e.name, "wr",     {31'd0, bus.if_id_write},  {31'd0, e.wr});
      chk(e.name, "flush",  {31'd0, bus.if_id_flush},  {31'd0, e.fl});
      chk(e.name, "bubble", {31'd0, bus.id_ex_bubble}, {31'd0, e.bub});
      chk(e.name, "state",  {30'd0, bus.state},        {30'd0, e.st});
      chk(e.name, "cnt",    {16'd0, bus.fetch_cnt},    {16'd0, e.cnt});
    end
  end

  task automatic push(input string n, input logic [31:0] npc, input logic wr, input logic fl,
                      input logic bub, input logic [1:0] st, input logic [15:0] cnt);
    exp_t e;
    e.name = n; e.npc = npc; e.wr = wr; e.fl = fl; e.bub = bub; e.st = st; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input string n, input logic [31:0] npc, input logic wr, input logic fl,
                     input logic bub, input logic [1:0] st, input logic [15:0] cnt);
    push(n, npc, wr, fl, bub, st, cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic run, input logic halt, input logic step, input logic haz,
                     input logic br, input logic [31:0] tgt);
    bus.run_req = run; bus.halt_req = halt; bus.step_req = step;
    bus.load_use_hazard = haz; bus.ctrl_branch = br; bus.branch_target = tgt;
  endtask

  initial begin
    rst = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.bp_en = 1'b0; bus.bp_addr = 32'h0;
    @(posedge clk);
    #1;
    cyc("reset", 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 16'd0);
    rst = 1'b1;

    // Run from reset into a breakpoint at 6
    bus.bp_en = 1'b1; bus.bp_addr = 32'h6;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("run_cmd", 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 16'd0);
    for (int i = 0; i < 6; i++)
      cyc("run_seq", 32'(i + 1), 1'b1, 1'b0, 1'b0, 2'b01, 16'(i));
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("bp_hit",  32'h6, 1'b0, 1'b0, 1'b1, 2'b01, 16'd6);
    cyc("bp_halt", 32'h6, 1'b0, 1'b0, 1'b1, 2'b00, 16'd6);

    // Single step over the breakpoint address
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc("step_cmd", 32'h6, 1'b0, 1'b0, 1'b1, 2'b00, 16'd6);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("step_acc", 32'h7, 1'b1, 1'b0, 1'b0, 2'b10, 16'd6);
    cyc("step_end", 32'h7, 1'b0, 1'b0, 1'b1, 2'b00, 16'd7);

    // Step held off by a two-cycle load-use stall
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc("hstep_cmd", 32'h7, 1'b0, 1'b0, 1'b1, 2'b00, 16'd7);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc("hstep_st1", 32'h7, 1'b0, 1'b0, 1'b1, 2'b10, 16'd7);
    cyc("hstep_st2", 32'h7, 1'b0, 1'b0, 1'b1, 2'b10, 16'd7);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("hstep_acc", 32'h8, 1'b1, 1'b0, 1'b0, 2'b10, 16'd7);
    cyc("hstep_end", 32'h8, 1'b0, 1'b0, 1'b1, 2'b00, 16'd8);

    // Run with stall, branch, branch-under-stall and PC wrap
    bus.bp_en = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("run2_cmd", 32'h8, 1'b0, 1'b0, 1'b1, 2'b00, 16'd8);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc("stall", 32'h8, 1'b0, 1'b0, 1'b1, 2'b01, 16'd8);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("post_stall", 32'h9, 1'b1, 1'b0, 1'b0, 2'b01, 16'd8);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    cyc("branch", 32'h20, 1'b1, 1'b1, 1'b0, 2'b01, 16'd9);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    cyc("br_stall", 32'h20, 1'b0, 1'b0, 1'b1, 2'b01, 16'd10);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("post_br", 32'h21, 1'b1, 1'b0, 1'b0, 2'b01, 16'd10);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc("br_top", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 2'b01, 16'd11);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("pc_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 2'b01, 16'd12);
    for (int i = 0; i < 19; i++)
      cyc("seq2", 32'(i + 1), 1'b1, 1'b0, 1'b0, 2'b01, 16'(13 + i));

    // Asynchronous reset mid-cycle at pc 0x13, held across an edge
    #1;
    rst = 1'b0;
    push("async_rst", 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 16'd0);
    @(posedge clk);
    #1;
    cyc("rst_hold", 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 16'd0);
    rst = 1'b1;

    // Halt request has priority over run
    cyc("run3_cmd", 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 16'd0);
    cyc("run3_acc", 32'h1, 1'b1, 1'b0, 1'b0, 2'b01, 16'd0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("halt_req", 32'h2, 1'b1, 1'b0, 1'b0, 2'b01, 16'd1);
    cyc("halted",   32'h2, 1'b0, 1'b0, 1'b1, 2'b00, 16'd2);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage of the 5-stage pipeline. It owns the architectural fetch PC and drives the `npc` input of the IF stage every cycle. It decides among hold, sequential fetch and branch redirect, based on run/halt/single-step commands, load-use stalls, branch resolution from ID and a single PC breakpoint. It also emits the IF/ID write-enable and flush controls, the ID/EX bubble request, and a fetch counter for the debug display.

## Interface
Parameters:
- `PC_W`, 32: PC width (word address; sequential increment is +1).
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `CNT_W`, 16: width of the fetch counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run_req`  in  1  level; request free-running fetch.
- `halt_req`  in  1  level; request halt. Has priority over `run_req`.
- `step_req`  in  1  single-cycle pulse; fetch exactly one instruction from HALT.
- `load_use_hazard`  in  1  from ID hazard detect; the ID instruction needs one stall cycle.
- `ctrl_branch`  in  1  branch/jump taken, resolved in ID.
- `branch_target`  in  PC_W  redirect address, valid with `ctrl_branch`.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  PC_W  breakpoint fetch address.
- `npc`  out  PC_W  next fetch PC; the IF stage loads it every edge.
- `if_id_write`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  squash the IF/ID register (wrong-path fetch).
- `id_ex_bubble`  out  1  insert a NOP into ID/EX.
- `state`  out  2  FSM state for display.
- `fetch_cnt`  out  CNT_W  number of accepted fetches.

## Operation
- Internal register `pc_q` holds the current fetch PC. Each edge: `pc_q <= npc`.
- FSM states, encoded in `state`: HALT=2'b00, RUN=2'b01, STEP=2'b10. The encoding 2'b11 is illegal and recovers to HALT.
- An **accept** occurs when state is RUN or STEP, `load_use_hazard`=0, and there is no breakpoint hit.
- A **breakpoint hit** occurs when `bp_en`=1, state is RUN, and `pc_q`==`bp_addr`.
- `npc` selection, in priority order:
  1. Not accepting (HALT, hazard or breakpoint hit) → `pc_q`.
  2. `ctrl_branch` → `branch_target`.
  3. Otherwise → `pc_q`+1, wrapping modulo 2^PC_W.
- Hazard wins over branch. A branch paired with a stalled ID instruction is ignored that cycle; ID re-asserts it next cycle.
- Output controls:
  - `if_id_write` = accept.
  - `if_id_flush` = accept & `ctrl_branch`.
  - `id_ex_bubble` = !accept. This covers stall, halt and breakpoint, so the back end drains.
- FSM transitions:
  - HALT: `halt_req` → HALT. Else `run_req` → RUN. Else `step_req` → STEP.
  - RUN: `halt_req` or breakpoint hit → HALT. Otherwise stay in RUN.
  - STEP: on accept → HALT. While `load_use_hazard`=1, stay in STEP. `halt_req` → HALT without fetching.
- Breakpoints are checked only in RUN. This lets a STEP fetch the instruction at `bp_addr`, so execution can resume past it.
- `fetch_cnt` increments by 1 on every accept, including branch redirects, and wraps at 2^CNT_W.

## Timing
- Reset (asynchronous, `rst`=0):
  - `pc_q`=RESET_PC, state=HALT, `fetch_cnt`=0.
  - Resulting outputs: `npc`=RESET_PC, `if_id_write`=0, `if_id_flush`=0, `id_ex_bubble`=1, `state`=2'b00.
- Reset asserted mid-RUN returns to these values immediately, independent of `clk`.
- `npc`, `if_id_write`, `if_id_flush` and `id_ex_bubble` are combinational from `pc_q`, state and the same-cycle inputs. There is no added latency: a branch in cycle N puts `branch_target` on `npc` in cycle N, and the IF PC holds it after edge N.
- State changes take effect one cycle after the command:
  - `run_req` high in HALT at edge N → first accept in cycle N+1.
  - `step_req` in cycle N → exactly one accept, in the first hazard-free cycle ≥ N+1, then HALT.
- `step_req` outside HALT is ignored.
- A load-use stall lasts exactly as many cycles as `load_use_hazard` is high. Each stall cycle holds `npc`=`pc_q` and bubbles ID/EX.

## Structure
- State encodings (HALT/RUN/STEP) go in the shared pipeline defines header, next to the instruction-type constants, so display logic can decode `state`.
- A single module; no sub-module is required. The next-PC priority mux may be a local function.

## Test plan
- Reset, then `run_req`=1 for 5 cycles → `npc` sequence 0,1,2,3,4,5. `fetch_cnt`=5. `if_id_write`=1 in cycles 1–5.
- RUN at `pc_q`=8, `load_use_hazard`=1 for 1 cycle → `npc`=8 held once, `id_ex_bubble`=1, `if_id_write`=0; then `npc`=9.
- RUN at `pc_q`=4, `ctrl_branch`=1, `branch_target`=0x20 → `npc`=0x20, `if_id_flush`=1 that cycle. With `load_use_hazard`=1 in the same cycle → `npc`=4 and no flush.
- `bp_en`=1, `bp_addr`=6, `run_req`=1 → halts with `pc_q`=6, `state`=00, `fetch_cnt`=6. A `step_req` pulse then gives one accept, `pc_q`=7, HALT again.
- `step_req` while `load_use_hazard`=1 for 2 cycles → STEP held for 2 cycles, then one accept, then HALT.
- `rst` pulsed low asynchronously mid-RUN at `pc_q`=0x13 → immediately `npc`=0, `state`=00, `fetch_cnt`=0.
